// File: rtl/fmac_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fmac_pkg
// Description : Shared types and constants for the fmac_seq dot-product
//               sequencer (state encoding, FloPoCo word helpers).
// Revision    : 1.0 - initial release
// ============================================================================
package fmac_pkg;

    // Sequencer states; explicit 3-bit encoding
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_MWAIT  = 3'd3,
        ST_AISSUE = 3'd4,
        ST_AWAIT  = 3'd5,
        ST_ACC    = 3'd6,
        ST_DONE   = 3'd7
    } fmac_state_t;

    // FloPoCo word: 2 exception bits, sign, WE exponent bits, WF fraction bits
    function automatic int fp_word_w(input int we, input int wf);
        return we + wf + 3;
    endfunction

    // Counter width able to hold max(a,b)-1
    function automatic int lat_cnt_w(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

    // FloPoCo exception codes
    localparam logic [1:0] EXC_ZERO   = 2'b00;
    localparam logic [1:0] EXC_NORMAL = 2'b01;
    localparam logic [1:0] EXC_INF    = 2'b10;
    localparam logic [1:0] EXC_NAN    = 2'b11;

    // All-zero word, sliced to the word width at the point of use
    localparam int          FP_MAX_W = 64;
    localparam logic [FP_MAX_W-1:0] FP_ZERO = '0;

endpackage : fmac_pkg
`default_nettype wire

// File: rtl/fmac_seq_lat_counter.sv
`default_nettype none
// ============================================================================
// Module      : lat_counter
// Description : Loadable down-counter with a zero flag. Counts the fixed
//               pipeline latency of the shared multiplier/adder cores.
// Revision    : 1.0 - initial release
// ============================================================================
module lat_counter #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    input  logic          dec_i,
    output logic          zero_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: load wins over decrement; saturate at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Count register with synchronous active-low clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule : lat_counter
`default_nettype wire

// File: rtl/fmac_seq.sv
`default_nettype none
// ============================================================================
// Module      : fmac_seq
// Description : Single-job dot-product sequencer. Fetches operand pairs,
//               drives shared external fmul/fadd cores on a fixed counter
//               schedule and accumulates result = init_val + sum x[k]*y[k].
// Revision    : 1.0 - initial release
// ============================================================================
module fmac_seq
    import fmac_pkg::*;
#(
    parameter int WE      = 8,
    parameter int WF      = 23,
    parameter int W       = fp_word_w(WE, WF),
    parameter int MUL_LAT = 2,
    parameter int ADD_LAT = 3,
    parameter int LEN_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [W-1:0]     init_val,
    output logic             busy,
    output logic             done,
    output logic [W-1:0]     result,
    output logic             rd_en,
    output logic [LEN_W-1:0] rd_addr,
    input  logic [W-1:0]     rd_x,
    input  logic [W-1:0]     rd_y,
    output logic [W-1:0]     fmul_x,
    output logic [W-1:0]     fmul_y,
    input  logic [W-1:0]     fmul_r,
    output logic [W-1:0]     fadd_x,
    output logic [W-1:0]     fadd_y,
    input  logic [W-1:0]     fadd_r
);

    localparam int          CW       = lat_cnt_w(MUL_LAT, ADD_LAT);
    localparam logic [CW-1:0] MUL_INIT = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] ADD_INIT = CW'(ADD_LAT - 1);
    localparam logic [W-1:0]  WZERO    = FP_ZERO[W-1:0];

    fmac_state_t      state_q, state_d;

    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] k_q, k_d;
    logic [W-1:0]     acc_q, acc_d;
    logic [W-1:0]     result_q, result_d;
    logic [W-1:0]     fmul_x_q, fmul_x_d;
    logic [W-1:0]     fmul_y_q, fmul_y_d;
    logic [W-1:0]     fadd_x_q, fadd_x_d;
    logic [W-1:0]     fadd_y_q, fadd_y_d;

    logic             cnt_load;
    logic [CW-1:0]    cnt_val;
    logic             cnt_dec;
    logic             cnt_zero;
    logic             last_pair;

    // k never wraps: len==0 never reaches ACC, so len-1 is always valid here
    assign last_pair = (k_q == (len_q - LEN_W'(1)));

    lat_counter #(
        .CW (CW)
    ) u_lat_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: fixed per-pair schedule, waits timed by the counter
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (start) state_d = (len == '0) ? ST_DONE : ST_FETCH;
            ST_FETCH:  state_d = ST_LOAD;
            ST_LOAD:   state_d = ST_MWAIT;
            ST_MWAIT:  if (cnt_zero) state_d = ST_AISSUE;
            ST_AISSUE: state_d = ST_AWAIT;
            ST_AWAIT:  if (cnt_zero) state_d = ST_ACC;
            ST_ACC:    state_d = last_pair ? ST_DONE : ST_FETCH;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Moore outputs and latency-counter control decoded from the state
    always_comb begin
        busy     = (state_q != ST_IDLE);
        done     = (state_q == ST_DONE);
        rd_en    = 1'b0;
        rd_addr  = '0;
        cnt_load = 1'b0;
        cnt_val  = '0;
        cnt_dec  = 1'b0;
        unique case (state_q)
            ST_FETCH: begin
                rd_en   = 1'b1;
                rd_addr = k_q;
            end
            ST_LOAD: begin
                cnt_load = 1'b1;
                cnt_val  = MUL_INIT;
            end
            ST_AISSUE: begin
                cnt_load = 1'b1;
                cnt_val  = ADD_INIT;
            end
            ST_MWAIT, ST_AWAIT: cnt_dec = 1'b1;
            default: ;
        endcase
    end

    // Datapath next-state: job latch, operand hold windows, accumulator
    always_comb begin
        len_d    = len_q;
        k_d      = k_q;
        acc_d    = acc_q;
        result_d = result_q;
        fmul_x_d = fmul_x_q;
        fmul_y_d = fmul_y_q;
        fadd_x_d = fadd_x_q;
        fadd_y_d = fadd_y_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d = len;
                    acc_d = init_val;
                    k_d   = '0;
                end
            end
            ST_LOAD: begin
                fmul_x_d = rd_x;
                fmul_y_d = rd_y;
            end
            ST_AISSUE: begin
                fadd_x_d = acc_q;
                fadd_y_d = fmul_r;
                fmul_x_d = WZERO;
                fmul_y_d = WZERO;
            end
            ST_ACC: begin
                acc_d    = fadd_r;
                fadd_x_d = WZERO;
                fadd_y_d = WZERO;
                if (!last_pair) k_d = k_q + LEN_W'(1);
            end
            ST_DONE: result_d = acc_q;
            default: ;
        endcase
    end

    // Datapath registers; reset aborts any job and clears the result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len_q    <= '0;
            k_q      <= '0;
            acc_q    <= WZERO;
            result_q <= WZERO;
            fmul_x_q <= WZERO;
            fmul_y_q <= WZERO;
            fadd_x_q <= WZERO;
            fadd_y_q <= WZERO;
        end else begin
            len_q    <= len_d;
            k_q      <= k_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            fmul_x_q <= fmul_x_d;
            fmul_y_q <= fmul_y_d;
            fadd_x_q <= fadd_x_d;
            fadd_y_q <= fadd_y_d;
        end
    end

    assign result = result_q;
    assign fmul_x = fmul_x_q;
    assign fmul_y = fmul_y_q;
    assign fadd_x = fadd_x_q;
    assign fadd_y = fadd_y_q;

endmodule : fmac_seq
`default_nettype wire

// File: tb/tb_fmac_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_fmac_seq
// Description : Self-checking bench for fmac_seq with real-valued fmul/fadd
//               pipeline models and a 1-cycle operand store.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fmac_seq;
    import fmac_pkg::*;

    localparam int WE      = 8;
    localparam int WF      = 23;
    localparam int W       = WE + WF + 3;
    localparam int MUL_LAT = 2;
    localparam int ADD_LAT = 3;
    localparam int LEN_W   = 8;
    localparam int P       = 4 + MUL_LAT + ADD_LAT;

    localparam logic [W-1:0] FP_1P0 = 34'h1_3F80_0000;
    localparam logic [W-1:0] FP_2P0 = 34'h1_4000_0000;
    localparam logic [W-1:0] FP_0P5 = 34'h1_3F00_0000;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic [W-1:0]     init_val = '0;
    logic             busy, done, rd_en;
    logic [W-1:0]     result;
    logic [LEN_W-1:0] rd_addr;
    logic [W-1:0]     rd_x, rd_y;
    logic [W-1:0]     fmul_x, fmul_y, fmul_r;
    logic [W-1:0]     fadd_x, fadd_y, fadd_r;

    logic [W-1:0]     mem_x [256];
    logic [W-1:0]     mem_y [256];
    logic [W-1:0]     mpipe [MUL_LAT];
    logic [W-1:0]     apipe [ADD_LAT];

    int n_assert = 0;
    int n_fail   = 0;

    // job monitor state
    bit       job_active = 0;
    int       job_cyc    = 0;
    int       done_cyc   = 0;
    int       rd_cnt     = 0;
    int       done_cnt   = 0;
    logic [W-1:0] last_fadd_r = '0;

    fmac_seq #(
        .WE(WE), .WF(WF), .W(W), .MUL_LAT(MUL_LAT), .ADD_LAT(ADD_LAT), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .init_val(init_val),
        .busy(busy), .done(done), .result(result),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_x(rd_x), .rd_y(rd_y),
        .fmul_x(fmul_x), .fmul_y(fmul_y), .fmul_r(fmul_r),
        .fadd_x(fadd_x), .fadd_y(fadd_y), .fadd_r(fadd_r)
    );

    always #5 clk = ~clk;

    function automatic real fp2r(input logic [W-1:0] w);
        logic [63:0] b;
        int e;
        case (w[W-1:W-2])
            EXC_ZERO: return 0.0;
            EXC_INF:  return w[W-3] ? -1.0e300 : 1.0e300;
            EXC_NAN:  return 1.0e300;
            default: begin
                e = int'(w[WF+WE-1:WF]) - 127 + 1023;
                b = {w[W-3], e[10:0], w[WF-1:0], 29'd0};
                return $bitstoreal(b);
            end
        endcase
    endfunction

    function automatic logic [W-1:0] r2fp(input real r);
        logic [63:0] b;
        int e;
        if (r == 0.0) return {EXC_ZERO, 32'd0};
        b = $realtobits(r);
        e = int'(b[62:52]) - 1023 + 127;
        return {EXC_NORMAL, b[63], e[7:0], b[51:29]};
    endfunction

    // external cores and operand store
    always @(posedge clk) begin
        mpipe[0] <= r2fp(fp2r(fmul_x) * fp2r(fmul_y));
        for (int i = 1; i < MUL_LAT; i++) mpipe[i] <= mpipe[i-1];
        apipe[0] <= r2fp(fp2r(fadd_x) + fp2r(fadd_y));
        for (int i = 1; i < ADD_LAT; i++) apipe[i] <= apipe[i-1];
        if (rd_en) begin
            rd_x <= mem_x[rd_addr];
            rd_y <= mem_y[rd_addr];
        end
    end
    assign fmul_r = mpipe[MUL_LAT-1];
    assign fadd_r = apipe[ADD_LAT-1];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // schedule checks derived from the per-pair cycle budget
    task automatic monitor();
        int o, p;
        if (job_cyc < done_cyc) begin
            o = (job_cyc - 1) % P;
            p = (job_cyc - 1) / P;
            chk("busy_in_job", busy, 1);
            chk("done_early", done, 0);
            chk("rd_en_slot", rd_en, (o == 0));
            if (rd_en) begin
                rd_cnt++;
                chk("rd_addr", rd_addr, p);
            end else begin
                chk("rd_addr_idle", rd_addr, 0);
            end
            if (fmul_x != '0 || fmul_y != '0)
                chk("fmul_window", (o >= 2 && o <= 2 + MUL_LAT), 1);
            if (fadd_x != '0 || fadd_y != '0)
                chk("fadd_window", (o >= 3 + MUL_LAT && o <= P - 1), 1);
            if (o == 2) begin
                chk("fmul_x_op", fmul_x, mem_x[p]);
                chk("fmul_y_op", fmul_y, mem_y[p]);
            end
            if (o == 3 + MUL_LAT) begin
                chk("fadd_y_prod", fadd_y, r2fp(fp2r(mem_x[p]) * fp2r(mem_y[p])));
                if (p >= 1) chk("fadd_x_chain", fadd_x, last_fadd_r);
            end
            if (o == P - 1) last_fadd_r = fadd_r;
        end else begin
            chk("done_cycle", done, 1);
            chk("busy_at_done", busy, 1);
            chk("rd_en_at_done", rd_en, 0);
            if (done) done_cnt++;
            job_active = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (job_active) begin
            job_cyc++;
            monitor();
        end
    endtask

    function automatic logic [W-1:0] ref_dot(input int n, input logic [W-1:0] init);
        real s;
        s = fp2r(init);
        for (int k = 0; k < n; k++) s = s + fp2r(mem_x[k]) * fp2r(mem_y[k]);
        return r2fp(s);
    endfunction

    task automatic run_job(input int n, input logic [W-1:0] init,
                           input logic [W-1:0] exp_res, input bit busy_start);
        int guard;
        start      = 1'b1;
        len        = LEN_W'(n);
        init_val   = init;
        job_active = 1;
        job_cyc    = 0;
        done_cyc   = 1 + n * P;
        rd_cnt     = 0;
        done_cnt   = 0;
        tick();
        start    = 1'b0;
        len      = LEN_W'($urandom);
        init_val = W'($urandom);
        guard    = 0;
        while (job_active && guard < 3000) begin
            start = (busy_start && job_cyc == 5);
            tick();
            guard++;
        end
        start = 1'b0;
        if (job_active) begin
            chk("done_timeout", 0, 1);
            job_active = 0;
        end
        chk("rd_pulses", rd_cnt, n);
        chk("done_pulses", done_cnt, 1);
        tick();
        chk("busy_after", busy, 0);
        chk("result", result, exp_res);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("done_quiet", done, 0);
            chk("rd_en_quiet", rd_en, 0);
        end
    endtask

    function automatic logic [W-1:0] rnd_word(input int lo, input int hi);
        real r;
        r = real'(int'($urandom_range(hi - lo)) + lo);
        if ($urandom_range(1) == 1) r = -r;
        return r2fp(r);
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_rd_en"}, rd_en, 0);
        chk({tag, "_rd_addr"}, rd_addr, 0);
        chk({tag, "_result"}, result, 0);
        chk({tag, "_fmul"}, {fmul_x, fmul_y}, 0);
        chk({tag, "_fadd"}, {fadd_x, fadd_y}, 0);
    endtask

    initial begin
        logic [W-1:0] e;
        int n;
        for (int i = 0; i < 256; i++) begin
            mem_x[i] = '0;
            mem_y[i] = '0;
        end

        // reset state
        rst_n = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();
        check_all_zero("idle");

        // basic job
        mem_x[0] = r2fp(1.0); mem_x[1] = r2fp(2.0); mem_x[2] = r2fp(3.0);
        mem_y[0] = r2fp(4.0); mem_y[1] = r2fp(5.0); mem_y[2] = r2fp(6.0);
        e = ref_dot(3, FP_0P5);
        chk("basic_model_const", e, 34'h1_4202_0000);
        run_job(3, FP_0P5, e, 0);

        // zero length
        run_job(0, FP_2P0, FP_2P0, 0);

        // start while busy is ignored
        run_job(3, FP_0P5, e, 1);

        // randomized jobs
        for (int j = 0; j < 4; j++) begin
            n = $urandom_range(12, 1);
            for (int k = 0; k < n; k++) begin
                mem_x[k] = rnd_word(1, 8);
                mem_y[k] = rnd_word(1, 8);
            end
            e = (j == 0) ? '0 : rnd_word(0, 20);
            run_job(n, e, ref_dot(n, e), (j % 2 == 1));
        end

        // reset during AWAIT of pair 1
        mem_x[0] = FP_1P0; mem_x[1] = FP_2P0; mem_x[2] = FP_1P0;
        mem_y[0] = FP_2P0; mem_y[1] = FP_2P0; mem_y[2] = FP_1P0;
        start = 1'b1; len = 8'd3; init_val = FP_0P5;
        job_active = 1; job_cyc = 0; done_cyc = 1 + 3 * P;
        tick();
        start = 1'b0;
        for (int g = 0; g < 100 && job_cyc < 1 + P + 3 + MUL_LAT; g++) tick();
        chk("pre_reset_busy", busy, 1);
        chk("pre_reset_fadd_active", (fadd_x != '0), 1);
        rst_n = 1'b0;
        job_active = 0;
        tick();
        check_all_zero("abort");
        start = 1'b1;
        tick();
        check_all_zero("start_in_reset");
        rst_n = 1'b1;
        start = 1'b0;
        tick();
        check_all_zero("after_reset");
        mem_x[0] = FP_2P0;
        mem_y[0] = FP_2P0;
        run_job(1, '0, 34'h1_4080_0000, 0);

        // max length
        for (int k = 0; k < 255; k++) begin
            mem_x[k] = FP_1P0;
            mem_y[k] = FP_1P0;
        end
        run_job(255, '0, 34'h1_437F_0000, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_fmac_seq
`default_nettype wire
